game_sequencer: RTL

//  Central run-time controller for the T-Rex game. Owns the IDLE/RUN/DEAD state, ramps the

---
 rtl/game_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer
//   Run-time controller for the T-Rex game. It holds the IDLE/RUN/DEAD game
//   state, ramps the horizontal scroll speed and schedules obstacle spawns
//   through a req/ack handshake. All game-time actions advance on frame_tick.
//
// Ports
//   clk, rst_n   : system clock, asynchronous active-low reset
//   frame_tick   : one-cycle strobe per video frame
//   jump         : debounced jump level (rising edge is the command)
//   collide      : dino/obstacle overlap, may be high in any cycle
//   spawn_ack    : obstacle delegate accepted the pending spawn
//   game_state   : 00 IDLE, 01 RUN, 10 DEAD
//   dx           : current scroll speed in px/frame
//   run_en       : high only while in RUN
//   spawn_req    : spawn request, held until acknowledged
//   spawn_type   : obstacle type, stable while spawn_req is high
//
// Configuration
//   TREX_BIRD_EN : when defined, lfsr value 3 yields a bird (type 3) once
//                  dx >= DX_INIT+2; otherwise value 3 is always remapped to 0.

module game_sequencer #(
  parameter int unsigned DX_INIT      = 5,
  parameter int unsigned DX_MAX       = 12,
  parameter int unsigned SPEED_FRAMES = 600,
  parameter int unsigned MIN_GAP      = 40,
  parameter int unsigned GAP_MASK     = 63,
  parameter int unsigned DEAD_HOLD    = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       jump,
  input  logic       collide,
  input  logic       spawn_ack,
  output logic [1:0] game_state,
  output logic [3:0] dx,
  output logic       run_en,
  output logic       spawn_req,
  output logic [1:0] spawn_type
);

  localparam int unsigned SPD_W  = (SPEED_FRAMES > 1) ? $clog2(SPEED_FRAMES) : 1;
  localparam int unsigned GAP_W  = $clog2(MIN_GAP + GAP_MASK + 1);
  localparam int unsigned HOLD_W = $clog2(DEAD_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        dx_q, dx_d;
  logic              run_en_q, run_en_d;
  logic              spawn_req_q, spawn_req_d;
  logic [1:0]        spawn_type_q, spawn_type_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [SPD_W-1:0]  spd_q, spd_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hit_q, hit_d;
  logic              jump_prev_q, jump_prev_d;

  logic              jump_edge;
  logic              lfsr_fb;
  logic              hit_now;
  logic [1:0]        type_mapped;
  logic [GAP_W-1:0]  gap_dec;
  logic [GAP_W-1:0]  gap_reload;

  assign jump_edge  = jump & ~jump_prev_q;
  assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign hit_now    = hit_q | collide;
  assign gap_dec    = (gap_q == '0) ? '0 : gap_q - GAP_W'(1);
  assign gap_reload = GAP_W'(MIN_GAP) + (lfsr_q[GAP_W-1:0] & GAP_W'(GAP_MASK));

  always_comb begin
    type_mapped = lfsr_q[1:0];
    if (lfsr_q[1:0] == 2'd3) begin
`ifdef TREX_BIRD_EN
      if (dx_q < 4'(DX_INIT + 2)) type_mapped = 2'd0;
`else
      type_mapped = 2'd0;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    dx_d         = dx_q;
    spawn_req_d  = spawn_req_q;
    spawn_type_d = spawn_type_q;
    lfsr_d       = lfsr_q;
    spd_d        = spd_q;
    gap_d        = gap_q;
    hold_d       = hold_q;
    hit_d        = hit_q;
    jump_prev_d  = jump;

    if (frame_tick) lfsr_d = {lfsr_q[14:0], lfsr_fb};

    unique case (state_q)
      ST_IDLE: begin
        if (jump_edge) begin
          state_d = ST_RUN;
          dx_d    = 4'(DX_INIT);
          spd_d   = '0;
          gap_d   = GAP_W'(MIN_GAP);
          hit_d   = 1'b0;
        end
      end

      ST_RUN: begin
        if (spawn_req_q && spawn_ack) spawn_req_d = 1'b0;

        if (frame_tick) begin
          if (hit_now) begin
            // Death takes priority over any spawn or speed step on this tick.
            state_d     = ST_DEAD;
            hit_d       = 1'b0;
            hold_d      = '0;
            spawn_req_d = 1'b0;
          end else begin
            if (spd_q == SPD_W'(SPEED_FRAMES - 1)) begin
              spd_d = '0;
              if (dx_q < 4'(DX_MAX)) dx_d = dx_q + 4'd1;
            end else begin
              spd_d = spd_q + SPD_W'(1);
            end

            // The gap keeps counting while a request is outstanding and parks
            // at zero, so the next spawn issues on the first tick after ack.
            if (!spawn_req_q && gap_dec == '0) begin
              spawn_req_d  = 1'b1;
              spawn_type_d = type_mapped;
              gap_d        = gap_reload;
            end else begin
              gap_d = gap_dec;
            end
          end
        end else begin
          hit_d = hit_now;
        end
      end

      ST_DEAD: begin
        if (frame_tick && hold_q < HOLD_W'(DEAD_HOLD)) hold_d = hold_q + HOLD_W'(1);
        if (jump_edge && hold_q == HOLD_W'(DEAD_HOLD)) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    run_en_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dx_q         <= 4'(DX_INIT);
      run_en_q     <= 1'b0;
      spawn_req_q  <= 1'b0;
      spawn_type_q <= '0;
      lfsr_q       <= 16'hACE1;
      spd_q        <= '0;
      gap_q        <= '0;
      hold_q       <= '0;
      hit_q        <= 1'b0;
      jump_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dx_q         <= dx_d;
      run_en_q     <= run_en_d;
      spawn_req_q  <= spawn_req_d;
      spawn_type_q <= spawn_type_d;
      lfsr_q       <= lfsr_d;
      spd_q        <= spd_d;
      gap_q        <= gap_d;
      hold_q       <= hold_d;
      hit_q        <= hit_d;
      jump_prev_q  <= jump_prev_d;
    end
  end

  assign game_state = state_q;
  assign dx         = dx_q;
  assign run_en     = run_en_q;
  assign spawn_req  = spawn_req_q;
  assign spawn_type = spawn_type_q;

endmodule
